// File: rtl/obi_data_mem_if.sv
// rtl/obi_data_mem_if.sv - data-side request/grant/response bus between core and memory slave
interface obi_data_mem_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/obi_data_mem.sv
// rtl/obi_data_mem.sv - data memory slave with grant delay, response latency and backdoor preload
module obi_data_mem #(
    parameter int          DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_DELAY       = 0,
    parameter int          RESP_LAT        = 1,
    parameter int          MAX_OUTSTANDING = 2,
    localparam int         AW              = $clog2(DEPTH_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    obi_data_mem_if.slave   bus,
    input  logic            bd_we_i,
    input  logic [AW-1:0]   bd_addr_i,
    input  logic [31:0]     bd_wdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    localparam logic [4:0] GD = 5'(GNT_DELAY);
    localparam logic [3:0] MO = 4'(MAX_OUTSTANDING);

    state_t      r_state;
    logic [4:0]  r_wait_cnt;
    logic [3:0]  r_outstanding;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic        r_pv  [RESP_LAT];
    logic [31:0] r_pd  [RESP_LAT];
    logic        r_pe  [RESP_LAT];

    logic [31:0] w_off;
    logic [31:0] w_word;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic        w_acc;
    logic        w_wr_hit;
    logic [31:0] w_rd;

    assign w_off      = bus.data_addr_i - BASE_ADDR;
    assign w_word     = w_off >> 2;
    assign w_in_range = (bus.data_addr_i >= BASE_ADDR) && (w_word < 32'(DEPTH_WORDS));
    assign w_idx      = w_word[AW-1:0];

    // Grant looks at the registered outstanding count, so a same-cycle retire frees nothing.
    assign w_acc    = !rst_i && (r_state == S_READY) && bus.data_req_i && (r_outstanding < MO);
    assign w_wr_hit = w_acc && bus.data_we_i && w_in_range;
    assign w_rd     = (w_in_range && !bus.data_we_i) ? r_mem[w_idx] : 32'h0;

    assign bus.data_gnt_o    = w_acc;
    assign bus.data_rvalid_o = r_pv[RESP_LAT-1];
    assign bus.data_rdata_o  = r_pd[RESP_LAT-1];
    assign bus.data_err_o    = r_pe[RESP_LAT-1];

    // Memory has no reset; a bus write to the same word overrides the backdoor.
    always_ff @(posedge clk_i) begin
        if (bd_we_i && !(w_wr_hit && (w_idx == bd_addr_i))) begin
            r_mem[bd_addr_i] <= bd_wdata_i;
        end
        if (w_wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 5'd0;
            r_outstanding <= 4'd0;
            for (int i = 0; i < RESP_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'h0;
                r_pe[i] <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (GNT_DELAY == 0) begin
                        r_state <= S_READY;
                    end else if (bus.data_req_i) begin
                        r_wait_cnt <= 5'd1;
                        r_state    <= (GD <= 5'd1) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.data_req_i) begin
                        r_wait_cnt <= 5'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 5'd1;
                        if (r_wait_cnt + 5'd1 >= GD) begin
                            r_state <= S_READY;
                        end
                    end
                end
                default: begin
                    if (w_acc) begin
                        r_wait_cnt <= 5'd0;
                        if (GNT_DELAY != 0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase

            r_outstanding <= r_outstanding + {3'b000, w_acc} - {3'b000, r_pv[RESP_LAT-1]};

            r_pv[0] <= w_acc;
            r_pd[0] <= w_acc ? w_rd : 32'h0;
            r_pe[0] <= w_acc && !w_in_range;
            for (int i = 1; i < RESP_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_obi_data_mem.sv
// tb/tb_obi_data_mem.sv - self-checking bench for obi_data_mem over four parameter sets
module tb_obi_data_mem;
    localparam int N = 4;

    function automatic int gd_of(input int i);
        return (i == 1) ? 3 : 0;
    endfunction
    function automatic int rl_of(input int i);
        return (i == 1) ? 2 : ((i == 3) ? 3 : 1);
    endfunction
    function automatic int mo_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } resp_t;

    logic           clk;
    logic [N-1:0]   rst, req, we, bd_we, gnt, rvalid, err;
    logic [3:0]     be       [N];
    logic [31:0]    addr     [N];
    logic [31:0]    wdata    [N];
    logic [31:0]    rdata    [N];
    logic [9:0]     bd_addr  [N];
    logic [31:0]    bd_wdata [N];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int GD = gd_of(g);
        localparam int RL = rl_of(g);
        localparam int MO = mo_of(g);

        obi_data_mem_if bus ();
        assign bus.data_req_i   = req[g];
        assign bus.data_we_i    = we[g];
        assign bus.data_be_i    = be[g];
        assign bus.data_addr_i  = addr[g];
        assign bus.data_wdata_i = wdata[g];
        assign gnt[g]    = bus.data_gnt_o;
        assign rvalid[g] = bus.data_rvalid_o;
        assign rdata[g]  = bus.data_rdata_o;
        assign err[g]    = bus.data_err_o;

        obi_data_mem #(
            .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DELAY(GD),
            .RESP_LAT(RL), .MAX_OUTSTANDING(MO)
        ) u_dut (
            .clk_i(clk), .rst_i(rst[g]), .bus(bus),
            .bd_we_i(bd_we[g]), .bd_addr_i(bd_addr[g]), .bd_wdata_i(bd_wdata[g])
        );

        // Reference: word array plus a queue of promised responses tagged with their due cycle.
        resp_t       q[$];
        logic [31:0] mm [1024];
        int          cyc = 0;
        int          run = 0;
        int          obs = 0;
        bit          armed = 1'b0;
        bit          fresh = 1'b0;

        always @(negedge clk) begin : model
            logic        ev, eg, inr;
            logic [31:0] rd;
            int          idx;
            resp_t       r;
            ev = 1'b0;
            eg = 1'b0;
            if (armed) begin
                ev = (q.size() > 0) && (q[0].due == cyc);
                eg = !rst[g] && req[g] && (run >= GD) && !(fresh && GD == 0) && (q.size() < MO);
                chk($sformatf("i%0d_gnt", g), 32'(gnt[g]), 32'(eg));
                chk($sformatf("i%0d_rvalid", g), 32'(rvalid[g]), 32'(ev));
                if (ev || fresh) begin
                    chk($sformatf("i%0d_rdata", g), rdata[g], ev ? q[0].d : 32'h0);
                    chk($sformatf("i%0d_err", g), 32'(err[g]), ev ? 32'(q[0].e) : 32'h0);
                end
            end
            if (rst[g]) begin
                q.delete();
                run   = 0;
                obs   = 0;
                fresh = 1'b1;
                armed = 1'b1;
            end else if (armed) begin
                obs = obs + int'(req[g] && gnt[g]) - int'(rvalid[g]);
                chk($sformatf("i%0d_outstanding_le_max", g), 32'(obs <= MO), 32'd1);
                if (ev) void'(q.pop_front());
                inr = (addr[g] >> 2) < 32'd1024;
                idx = inr ? int'(addr[g] >> 2) : 0;
                rd  = (inr && !we[g]) ? mm[idx] : 32'h0;
                if (bd_we[g] && !(eg && we[g] && inr && idx == int'(bd_addr[g])))
                    mm[bd_addr[g]] = bd_wdata[g];
                if (eg) begin
                    if (we[g] && inr)
                        for (int b = 0; b < 4; b++)
                            if (be[g][b]) mm[idx][8*b +: 8] = wdata[g][8*b +: 8];
                    r.due = cyc + RL;
                    r.d   = rd;
                    r.e   = !inr;
                    q.push_back(r);
                end
                run   = (eg || !req[g]) ? 0 : run + 1;
                fresh = 1'b0;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd(input int i, input int a, input logic [31:0] d);
        bd_we[i]    = 1'b1;
        bd_addr[i]  = 10'(a);
        bd_wdata[i] = d;
        step();
        bd_we[i] = 1'b0;
    endtask

    // Holds the request until granted; gc = cycles from request to grant.
    task automatic issue(input int i, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, output int gc);
        gc       = -1;
        req[i]   = 1'b1;
        we[i]    = w;
        be[i]    = b;
        addr[i]  = a;
        wdata[i] = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gnt[i]) begin
                gc = k;
                break;
            end
        end
        step();
        req[i] = 1'b0;
        we[i]  = 1'b0;
        if (gc < 0) chk("gnt_timeout", 32'hFFFF_FFFF, 32'h0);
    endtask

    // lat counts cycles after the grant cycle until rvalid.
    task automatic wait_resp(input int i, output logic [31:0] d, output logic e, output int lat);
        lat = -1;
        d   = 32'h0;
        e   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rvalid[i]) begin
                lat = k + 1;
                d   = rdata[i];
                e   = err[i];
                break;
            end
        end
        step();
        if (lat < 0) chk("rvalid_timeout", 32'hFFFF_FFFF, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          gc, lat, ng, nr, last, seen;
        logic [31:0] d;
        logic        e;
        rst = '1; req = '0; we = '0; bd_we = '0;
        for (int i = 0; i < N; i++) begin
            be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
            bd_addr[i] = 10'h0; bd_wdata[i] = 32'h0;
        end
        repeat (3) step();
        rst = '0;
        step();
        step();

        // Default parameters: plain read after backdoor preload.
        bd(0, 4, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'hF, 32'h10, 32'h0, gc);
        chk("t1_gnt_lat", gc, 0);
        wait_resp(0, d, e, lat);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_err", 32'(e), 0);
        chk("t1_lat", lat, 1);

        // Byte-enable write then read back.
        bd(0, 2, 32'h1122_3344);
        issue(0, 1'b1, 4'b0101, 32'h8, 32'hAABB_CCDD, gc);
        wait_resp(0, d, e, lat);
        chk("t2_wr_rdata", d, 32'h0);
        chk("t2_wr_err", 32'(e), 0);
        issue(0, 1'b0, 4'hF, 32'h8, 32'h0, gc);
        wait_resp(0, d, e, lat);
        chk("t2_rdata", d, 32'h11BB_33DD);

        // Out of range around the top of memory.
        bd(0, 0, 32'h0BAD_F00D);
        bd(0, 1023, 32'h1234_5678);
        issue(0, 1'b0, 4'hF, 32'h1000, 32'h0, gc);
        wait_resp(0, d, e, lat);
        chk("t3_oor_rd_err", 32'(e), 1);
        chk("t3_oor_rd_data", d, 32'h0);
        issue(0, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, gc);
        wait_resp(0, d, e, lat);
        chk("t3_oor_wr_err", 32'(e), 1);
        issue(0, 1'b0, 4'hF, 32'h0, 32'h0, gc);
        wait_resp(0, d, e, lat);
        chk("t3_word0_kept", d, 32'h0BAD_F00D);
        issue(0, 1'b0, 4'hF, 32'hFFC, 32'h0, gc);
        wait_resp(0, d, e, lat);
        chk("t3_last_err", 32'(e), 0);
        chk("t3_last_data", d, 32'h1234_5678);

        // Grant delay 3, response latency 2, then aborted request.
        bd(1, 4, 32'hCAFE_0001);
        issue(1, 1'b0, 4'hF, 32'h10, 32'h0, gc);
        chk("t4_gnt_lat", gc, 3);
        wait_resp(1, d, e, lat);
        chk("t4_lat", lat, 2);
        chk("t4_rdata", d, 32'hCAFE_0001);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; be[1] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) req[1] = 1'b0;
            @(negedge clk);
            chk($sformatf("t4_drop_gnt%0d", k), 32'(gnt[1]), 0);
            step();
        end
        issue(1, 1'b0, 4'hF, 32'h10, 32'h0, gc);
        chk("t4_restart_gnt_lat", gc, 3);
        wait_resp(1, d, e, lat);

        // One outstanding, latency 1: continuous reads every other cycle.
        for (int k = 0; k < 8; k++) bd(2, k, 32'h100 + k);
        req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h0;
        ng = 0; nr = 0; last = 0;
        for (int c = 0; c < 60 && (ng < 8 || nr < 8); c++) begin
            @(negedge clk);
            if (rvalid[2]) begin
                chk($sformatf("t5_order%0d", nr), rdata[2], 32'h100 + nr);
                nr++;
            end
            if (req[2] && gnt[2]) begin
                if (ng > 0) chk("t5_gap", c - last, 2);
                last = c;
                ng++;
            end
            step();
            if (ng == 8) req[2] = 1'b0;
            else addr[2] = 32'(ng * 4);
        end
        chk("t5_grants", ng, 8);
        chk("t5_responses", nr, 8);

        // Reset one cycle after acceptance drops the in-flight read.
        bd(3, 5, 32'h5A5A_0005);
        issue(3, 1'b0, 4'hF, 32'h14, 32'h0, gc);
        chk("t6_gnt_lat", gc, 0);
        rst[3] = 1'b1;
        step();
        rst[3] = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctrl", {29'h0, gnt[3], rvalid[3], err[3]}, 32'h0);
        chk("t6_rst_rdata", rdata[3], 32'h0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rvalid[3]) seen++;
        end
        chk("t6_no_rvalid", seen, 0);
        step();
        issue(3, 1'b0, 4'hF, 32'h14, 32'h0, gc);
        wait_resp(3, d, e, lat);
        chk("t6_lat", lat, 3);
        chk("t6_mem_kept", d, 32'h5A5A_0005);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
